// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit for the bus datapath.
// One control step per clock; strobes decode the current step and ir[31:27].
module control_sequencer #(
  parameter int unsigned OPW = 5,
  parameter int unsigned IRW = 32
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [IRW-1:0] ir,
  input  logic           stop,
  input  logic           resume,
  output logic           run,
  output logic           illegal_op,
  output logic [OPW-1:0] alu_op,
  output logic           pc_out,
  output logic           zlo_out,
  output logic           zhi_out,
  output logic           mdr_out,
  output logic           pc_enable,
  output logic           pc_increment,
  output logic           mar_enable,
  output logic           mdr_enable,
  output logic           read,
  output logic           ir_enable,
  output logic           y_enable,
  output logic           z_enable,
  output logic           lo_enable,
  output logic           hi_enable,
  output logic           gra,
  output logic           grb,
  output logic           grc,
  output logic           r_in,
  output logic           r_out,
  output logic           ba_out,
  output logic           c_sign_extended_out,
  output logic           ram_write,
  output logic           con_enable
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_AND  = OPW'(10);
  localparam logic [OPW-1:0] OP_OR   = OPW'(11);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(13);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(18);

  state_t         r_state;
  state_t         w_last_step;
  logic [OPW-1:0] w_op;
  logic [OPW-1:0] w_imm_alu;
  logic           w_is_mem;
  logic           w_is_ld;
  logic           w_is_st;
  logic           w_is_ldi;
  logic           w_is_alu;
  logic           w_is_imm;
  logic           w_is_md;
  logic           w_is_un;
  logic           w_unused_ir;

  assign w_op        = ir[IRW-1 -: OPW];
  assign w_unused_ir = ^ir[IRW-OPW-1:0];

  // Opcode class decode
  assign w_is_ld  = (w_op == OP_LD);
  assign w_is_ldi = (w_op == OP_LDI);
  assign w_is_st  = (w_op == OP_ST);
  assign w_is_mem = w_is_ld | w_is_ldi | w_is_st;
  assign w_is_alu = (w_op >= OP_ADD) && (w_op <= OP_OR);
  assign w_is_imm = (w_op >= OP_ADDI) && (w_op <= OP_ORI);
  assign w_is_md  = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_is_un  = (w_op == OP_NEG) || (w_op == OP_NOT);

  // Immediate ops reuse the ALU code of their register counterpart
  always_comb begin
    w_imm_alu = OP_ADD;
    if (w_op == OP_ANDI) w_imm_alu = OP_AND;
    if (w_op == OP_ORI)  w_imm_alu = OP_OR;
  end

  // Final control step of the instruction currently in ir
  always_comb begin
    w_last_step = S_T3;
    if (w_is_ld || w_is_st)             w_last_step = S_T7;
    else if (w_is_md)                   w_last_step = S_T6;
    else if (w_is_ldi || w_is_alu || w_is_imm) w_last_step = S_T5;
    else if (w_is_un)                   w_last_step = S_T4;
  end

  // Step sequencing; stop only takes effect on an instruction's last step
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_T0;
        S_T0:    r_state <= S_T1;
        S_T1:    r_state <= S_T2;
        S_T2:    r_state <= S_T3;
        S_HALT:  r_state <= resume ? S_T0 : S_HALT;
        default: begin
          if (r_state == w_last_step) r_state <= stop ? S_HALT : S_T0;
          else                        r_state <= state_t'(4'(r_state) + 4'd1);
        end
      endcase
    end
  end

  assign run = (r_state != S_IDLE) && (r_state != S_HALT);

  // ir is loaded on the T2 edge, so strobes decode it combinationally from T3 on
  always_comb begin
    illegal_op = 1'b0; alu_op = '0;
    pc_out = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0; mdr_out = 1'b0;
    pc_enable = 1'b0; pc_increment = 1'b0; mar_enable = 1'b0; mdr_enable = 1'b0;
    read = 1'b0; ir_enable = 1'b0; y_enable = 1'b0; z_enable = 1'b0;
    lo_enable = 1'b0; hi_enable = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0;
    r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0; c_sign_extended_out = 1'b0;
    ram_write = 1'b0; con_enable = 1'b0;
    case (r_state)
      S_T0: begin pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1; end
      S_T1: begin zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1; end
      S_T2: begin mdr_out = 1'b1; ir_enable = 1'b1; end
      S_T3: begin
        if (w_is_mem) begin
          grb = 1'b1; ba_out = 1'b1; y_enable = 1'b1;
        end else if (w_is_alu || w_is_imm) begin
          grb = 1'b1; r_out = 1'b1; y_enable = 1'b1;
        end else if (w_is_md) begin
          gra = 1'b1; r_out = 1'b1; y_enable = 1'b1;
        end else if (w_is_un) begin
          grb = 1'b1; r_out = 1'b1; alu_op = w_op; z_enable = 1'b1;
        end else begin
          illegal_op = 1'b1;
        end
      end
      S_T4: begin
        if (w_is_mem) begin
          c_sign_extended_out = 1'b1; alu_op = OP_ADD; z_enable = 1'b1;
        end else if (w_is_alu) begin
          grc = 1'b1; r_out = 1'b1; alu_op = w_op; z_enable = 1'b1;
        end else if (w_is_imm) begin
          c_sign_extended_out = 1'b1; alu_op = w_imm_alu; z_enable = 1'b1;
        end else if (w_is_md) begin
          grb = 1'b1; r_out = 1'b1; alu_op = w_op; z_enable = 1'b1;
        end else if (w_is_un) begin
          zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end
      end
      S_T5: begin
        if (w_is_ldi || w_is_alu || w_is_imm) begin
          zlo_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end else if (w_is_ld || w_is_st) begin
          zlo_out = 1'b1; mar_enable = 1'b1;
        end else if (w_is_md) begin
          zlo_out = 1'b1; lo_enable = 1'b1;
        end
      end
      S_T6: begin
        if (w_is_ld) begin
          read = 1'b1; mdr_enable = 1'b1;
        end else if (w_is_st) begin
          gra = 1'b1; r_out = 1'b1; mdr_enable = 1'b1;
        end else if (w_is_md) begin
          zhi_out = 1'b1; hi_enable = 1'b1;
        end
      end
      S_T7: begin
        if (w_is_ld) begin
          mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1;
        end else if (w_is_st) begin
          ram_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the bus-based datapath: fetch, decode, execute, one control step per clock.
- Produces the same datapath strobes the phase-2 benches drive by hand (pc_out, mar_enable, gra/grb/grc, r_in/r_out, ba_out, c_sign_extended_out, ...), decoded from the IR opcode.
- Sits beside the datapath; receives ir, drives all control inputs, and replaces bench-driven control.

Parameters:
- OPW, 5, opcode width (ir[31:27])
- IRW, 32, instruction register width

Ports:
- clk  in  1  system clock, all state changes on rising edge
- clr  in  1  reset, synchronous, active-high
- ir  in  IRW  current instruction register contents from datapath
- stop  in  1  halt request, sampled at instruction boundary
- resume  in  1  leave HALT
- run  out  1  high unless in IDLE or HALT
- illegal_op  out  1  one-cycle pulse on undefined opcode
- alu_op  out  OPW  operation select to ALU
- pc_out, zlo_out, zhi_out, mdr_out, pc_enable, pc_increment, mar_enable, mdr_enable, read, ir_enable, y_enable, z_enable, lo_enable, hi_enable, gra, grb, grc, r_in, r_out, ba_out, c_sign_extended_out, ram_write, con_enable  out  1 each  datapath strobes

Behaviour:
- States: IDLE, T0..T7, HALT. Outputs are a decode of state + ir[31:27]; unlisted strobes are 0; alu_op = 0 unless stated.
- clr high at an edge: state <- IDLE, all strobes 0, run 0; this aborts any instruction mid-step. The first edge with clr low goes IDLE -> T0.
- Fetch:
  - T0: pc_out, mar_enable, pc_increment, z_enable.
  - T1: zlo_out, pc_enable, read, mdr_enable.
  - T2: mdr_out, ir_enable.
  - The opcode is decoded from ir at T3 and later.
- Opcodes:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011
  - addi 01100, andi 01101, ori 01110
  - mul 01111, div 10000, neg 10001, not 10010
- ldi:
  - T3: grb, ba_out, y_enable.
  - T4: c_sign_extended_out, alu_op=00011, z_enable.
  - T5: zlo_out, gra, r_in.
- ld:
  - T3, T4 as ldi.
  - T5: zlo_out, mar_enable.
  - T6: read, mdr_enable.
  - T7: mdr_out, gra, r_in.
- st:
  - T3, T4 as ldi.
  - T5: zlo_out, mar_enable.
  - T6: gra, r_out, mdr_enable (read=0).
  - T7: ram_write.
- Register ALU ops (00011..01011):
  - T3: grb, r_out, y_enable.
  - T4: grc, r_out, alu_op=opcode, z_enable.
  - T5: zlo_out, gra, r_in.
- Immediate ops (addi, andi, ori):
  - T3 as the register ALU ops.
  - T4: c_sign_extended_out, alu_op=add/and/or code respectively, z_enable.
  - T5: zlo_out, gra, r_in.
- mul/div:
  - T3: gra, r_out, y_enable.
  - T4: grb, r_out, alu_op=opcode, z_enable.
  - T5: zlo_out, lo_enable.
  - T6: zhi_out, hi_enable.
- neg/not:
  - T3: grb, r_out, alu_op=opcode, z_enable.
  - T4: zlo_out, gra, r_in.
- Last step of each instruction: next state T0, or HALT if stop=1 at that edge.
- Undefined opcode: T3 asserts illegal_op only, then next state T0 (or HALT if stop=1).
- HALT:
  - All strobes 0, run 0.
  - resume=1 -> T0.
  - stop and resume both high in HALT: resume wins.
  - stop is ignored except on last-step edges.
- At most one of pc_out, zlo_out, zhi_out, mdr_out, r_out, c_sign_extended_out is high in any state (bus exclusivity). Violation is a design error; the bench checks it every cycle.
- Instruction lengths (cycles T0 to last step): ldi 6, ld/st 8, ALU 6, imm 6, mul/div 7, neg/not 5, illegal 4.

Test Plan:
- clr=1 for 2 cycles, then low -> all strobes 0 and run=0 during clr; T0 strobes (pc_out, mar_enable, pc_increment, z_enable) on the 1st cycle after release.
- ir=0x09000095 (ldi R2,0x95) -> T3 grb+ba_out+y_enable; T4 c_sign_extended_out+z_enable, alu_op=00011; T5 zlo_out+gra+r_in; T0 the next cycle. Then ir=0x08100038 (ldi R0,0x38(R2)) -> identical strobe sequence.
- ir=0x1A920000 (add R5,R2,R4) -> T4 grc+r_out with alu_op=00011; 6-cycle instruction. mul -> T5 lo_enable, T6 hi_enable, 7 cycles.
- st sequence -> ram_write high exactly 1 cycle at T7, never with read. ld -> read at T1 and T6 only.
- ir[31:27]=11111 -> illegal_op pulses 1 cycle at T3, then T0. stop=1 at that edge -> HALT, run=0; resume pulse -> T0.
- clr asserted at T5 of ld -> IDLE at the next edge, no r_in/ram_write afterwards. Bus-exclusivity assertion holds over all opcodes.
